serial_adder: RTL

Bit-serial N-bit adder that consumes operand words and produces their sum one bit per clock. The datapath is the team's half-adder pair (sum = a^b, carry = a&b) cascaded into a full-adder cell, with a carry flip-flop closing the loop. It sits directly downstream of the operand source and feeds the combinational half-adder stage one bit position per cycle. It trades WIDTH cycles of latency for a single-bit adder datapath.

---
 rtl/serial_adder.sv | 118 +++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one sum bit per clock through a full-adder cell
// with a carry flip-flop. The result {c,s} is registered and held until the next completion.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic [WIDTH-1:0] r_rs;
    logic             r_cy;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_s;
    logic             r_c;

    logic             w_ha0_s;
    logic             w_ha0_c;
    logic             w_bit;
    logic             w_cy_nxt;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_rs_nxt;

    // Half-adder pair cascaded into a full adder; the second half-adder's carry merges into w_cy_nxt.
    assign w_ha0_s  = r_ra[0] ^ r_rb[0];
    assign w_ha0_c  = r_ra[0] & r_rb[0];
    assign w_bit    = w_ha0_s ^ r_cy;
    assign w_cy_nxt = w_ha0_c | (w_ha0_s & r_cy);

    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_state == SHIFT) && (r_cnt == CW'(WIDTH - 1));

    generate
        if (WIDTH == 1) begin : g_rs_w1
            assign w_rs_nxt = w_bit;
        end else begin : g_rs_wn
            assign w_rs_nxt = {w_bit, r_rs[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_nxt = SHIFT;
            SHIFT:   if (w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath and registered outputs; s/c only move on the completing edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ra   <= '0;
            r_rb   <= '0;
            r_rs   <= '0;
            r_cy   <= 1'b0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_s    <= '0;
            r_c    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_ra   <= a;
                r_rb   <= b;
                r_rs   <= '0;
                r_cy   <= 1'b0;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_state == SHIFT) begin
                r_ra  <= r_ra >> 1;
                r_rb  <= r_rb >> 1;
                r_rs  <= w_rs_nxt;
                r_cy  <= w_cy_nxt;
                r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                    r_s    <= w_rs_nxt;
                    r_c    <= w_cy_nxt;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign s    = r_s;
    assign c    = r_c;

endmodule
